pci_bus_arbiter: RTL

//  Central arbiter for the shared PCI bus segment (devices A/B/C and future agents).

---
 rtl/pci_pkg.sv | 12 +
 rtl/pci_rr_picker.sv | 25 ++
 rtl/pci_bus_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// pci_pkg: shared PCI arbiter state type and bus constants.
package pci_pkg;
  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, TURNAROUND} arb_state_t;
  localparam logic [31:0] DEV_A_ADDR = 32'hAD;
  localparam logic [31:0] DEV_B_ADDR = 32'hBD;
  localparam logic [31:0] DEV_C_ADDR = 32'hCD;
  localparam logic [3:0] CBE_WRITE = 4'b0011;
  localparam logic [3:0] CBE_READ = 4'b0010;
  function automatic logic bus_idle(input logic frame, input logic irdy);
    return frame && irdy;
  endfunction
endpackage

// File: rtl/pci_rr_picker.sv
// pci_rr_picker: round-robin winner search starting just after the last owner.
module pci_rr_picker #(
  parameter int N_DEV = 3,
  localparam int IW = $clog2(N_DEV)
) (
  input  logic [N_DEV-1:0] req_n,
  input  logic [IW-1:0]    rr,
  output logic             valid,
  output logic [IW-1:0]    winner
);
  logic [IW-1:0] idx;
  // Scan from the far end so the nearest requester after rr is written last.
  always_comb begin
    valid = 1'b0;
    winner = '0;
    idx = '0;
    for (int i = N_DEV; i >= 1; i--) begin
      idx = IW'((int'(rr) + i) % N_DEV);
      if (!req_n[idx]) begin
        valid = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: round-robin PCI REQ#/GNT# arbiter that tracks bus ownership,
// parks an idle bus on one device and revokes grants that are never used.
module pci_bus_arbiter
  import pci_pkg::*;
#(
  parameter int N_DEV = 3,
  parameter int GNT_TIMEOUT = 16,
  parameter int PARK_DEV = 0,
  localparam int OW = $clog2(N_DEV + 1),
  localparam int IW = $clog2(N_DEV),
  localparam int TW = $clog2(GNT_TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] REQ,
  output logic [N_DEV-1:0] GNT,
  input  logic             FRAME,
  input  logic             IRDY,
  output logic [OW-1:0]    owner,
  output logic             bus_busy,
  output logic             timeout_evt
);
  localparam bit PARK_EN = PARK_DEV < N_DEV;
  localparam logic [N_DEV-1:0] PARK_GNT = PARK_EN ? ~(N_DEV'(1) << PARK_DEV) : '1;
  localparam logic [OW-1:0] PARK_OWNER = OW'(PARK_EN ? PARK_DEV : N_DEV);
  arb_state_t state;
  logic [IW-1:0] rr;
  logic [IW-1:0] pick;
  logic [IW-1:0] own_idx;
  logic [TW-1:0] timer;
  logic [N_DEV-1:0] req_n;
  logic pick_valid;
  logic parked;
  logic timed_out;
  // An undriven (X/Z) request line counts as no request.
  always_comb begin
    req_n = '1;
    for (int i = 0; i < N_DEV; i++) req_n[i] = (REQ[i] === 1'b0) ? 1'b0 : 1'b1;
  end
  assign own_idx = IW'(owner);
  assign parked = PARK_EN && (owner == OW'(PARK_DEV));
  assign timed_out = timer == TW'(GNT_TIMEOUT - 1);
  pci_rr_picker #(.N_DEV(N_DEV)) u_picker (
    .req_n (req_n),
    .rr    (rr),
    .valid (pick_valid),
    .winner(pick)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      GNT <= '1;
      owner <= OW'(N_DEV);
      bus_busy <= 1'b0;
      timeout_evt <= 1'b0;
      rr <= IW'(N_DEV - 1);
      timer <= '0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        IDLE:
          if (!FRAME && parked) begin
            state <= BUSY;
            bus_busy <= 1'b1;
          end else if (pick_valid) begin
            state <= GRANTED;
            GNT <= ~(N_DEV'(1) << pick);
            owner <= OW'(pick);
            timer <= '0;
          end else begin
            GNT <= PARK_GNT;
            owner <= PARK_OWNER;
          end
        GRANTED:
          if (!FRAME) begin
            state <= BUSY;
            bus_busy <= 1'b1;
          end else if (req_n[own_idx] || timed_out) begin
            state <= IDLE;
            GNT <= '1;
            owner <= OW'(N_DEV);
            rr <= own_idx;
            timeout_evt <= !req_n[own_idx];
          end else begin
            timer <= (&timer) ? timer : timer + 1'b1;
          end
        BUSY:
          if (bus_idle(FRAME, IRDY)) begin
            state <= TURNAROUND;
            GNT <= '1;
            bus_busy <= 1'b0;
            rr <= own_idx;
            owner <= OW'(N_DEV);
          end
        TURNAROUND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
